spi_master_regfile: RTL and testbench

//  CPU-mapped SPI master: small register bank accessed with the MT/MF ctrl codes (MTC0/MFC0 path)

---
 rtl/spi_master_regfile.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_spi_master_regfile.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_regfile.sv
// spi_master_regfile
//   CPU-mapped SPI master. A small register bank, accessed with the CPU's
//   MT (write) / MF (read) ctrl codes, drives a full-duplex SPI engine with
//   a programmable mode, clock divider and bit order. It also has a one-deep
//   TX holding buffer, RX valid/overrun flags and an interrupt.
//
//   Register map (word addresses):
//     0 TX   (W)        write starts a frame or fills the holding buffer
//     1 RX   (R)        last received frame; an MF read clears rx_dv
//     2 STAT (R, W1C)   [0] busy [1] rx_dv [2] tx_pend [3] tx_ovr [4] rx_ovr
//     3 CFG  (R/W)      [0] CPHA [1] CPOL [2] lsb_first [3] ie [15:8] div
//     4.. scratch (R/W)
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous reset, active-low
//   addr      in   register address
//   wd        in   write data
//   ctrl      in   CtrlMt = write, CtrlMf = read, anything else = idle
//   data_out  out  registered read data, zero on cycles without a read
//   spi_sclk  out  serial clock
//   spi_mosi  out  master-out data
//   spi_miso  in   master-in data, synchronous to clk
//   spi_cs_n  out  chip select, active-low
//   irq       out  rx_dv & CFG.ie
module spi_master_regfile #(
    parameter int unsigned       W_DATA   = 32,
    parameter int unsigned       W_ADDR   = 5,
    parameter int unsigned       W_CTRL   = 2,
    parameter int unsigned       DEF_DIV  = 4,
    parameter int unsigned       DEF_MODE = 0,
    parameter logic [W_CTRL-1:0] CtrlMt   = W_CTRL'(1),
    parameter logic [W_CTRL-1:0] CtrlMf   = W_CTRL'(2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_ADDR-1:0] addr,
    input  logic [W_DATA-1:0] wd,
    input  logic [W_CTRL-1:0] ctrl,
    output logic [W_DATA-1:0] data_out,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n,
    output logic              irq
);

    localparam int unsigned       NumRegs  = 2 ** W_ADDR;
    localparam int unsigned       HalfW    = $clog2(2 * W_DATA);
    localparam logic [HalfW-1:0]  LastHalf = HalfW'(2 * W_DATA - 1);
    localparam logic [1:0]        DefMode  = 2'(DEF_MODE);
    localparam logic [7:0]        DefDiv   = 8'(DEF_DIV);
    // The div field only exists when the CPU word reaches bit 15.
    localparam bit                HasDiv   = (W_DATA >= 16);

    localparam logic [W_ADDR-1:0] AddrTx    = W_ADDR'(0);
    localparam logic [W_ADDR-1:0] AddrRx    = W_ADDR'(1);
    localparam logic [W_ADDR-1:0] AddrStat  = W_ADDR'(2);
    localparam logic [W_ADDR-1:0] AddrCfg   = W_ADDR'(3);
    localparam logic [W_ADDR-1:0] AddrFirst = W_ADDR'(4);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

    state_e state_q, state_d;

    // Programmed configuration (CPU visible).
    logic             cfg_cpha_q, cfg_cpol_q, cfg_lsb_q, cfg_ie_q;
    logic [7:0]       cfg_div_q;
    // Configuration latched at frame start; used by the engine for the whole frame.
    logic             act_cpha_q, act_cpol_q, act_lsb_q;
    logic [7:0]       act_div_q;

    logic [7:0]       cnt_q;
    logic [HalfW-1:0] half_q;
    logic [W_DATA-1:0] tx_sh_q, rx_sh_q, hold_q, rx_q, data_out_q;
    logic             tx_pend_q, tx_ovr_q, rx_dv_q, rx_ovr_q;
    logic             tx_pend_d, tx_ovr_d, rx_dv_d, rx_ovr_d;
    logic [W_DATA-1:0] hold_d;
    logic [W_DATA-1:0] scratch_q [AddrFirst:NumRegs-1];

    logic        write_en, read_en;
    logic        wr_tx, wr_stat, wr_cfg, rd_rx;
    logic        busy, start_new, start_pend, frame_start;
    logic [7:0]  div_eff;
    logic        phase_end, last_half;
    logic        enter_h0, enter_next, enter_even, enter_odd;
    logic        do_sample, do_shift, hold_entry;
    logic        tx_bit;
    logic [15:0] wd16, cfg16;
    logic [4:0]  stat;
    logic [W_DATA-1:0] rd_data;

    // ------------------------------------------------------------------
    // Decode and engine timing
    // ------------------------------------------------------------------
    assign write_en = (ctrl == CtrlMt);
    assign read_en  = (ctrl == CtrlMf);
    assign wr_tx    = write_en && (addr == AddrTx);
    assign wr_stat  = write_en && (addr == AddrStat);
    assign wr_cfg   = write_en && (addr == AddrCfg);
    assign rd_rx    = read_en && (addr == AddrRx);

    assign start_new   = (state_q == StIdle) && wr_tx && !tx_pend_q;
    assign start_pend  = (state_q == StIdle) && tx_pend_q;
    assign frame_start = start_new || start_pend;

    assign div_eff   = (act_div_q == 8'd0) ? 8'd1 : act_div_q;
    assign phase_end = (cnt_q == div_eff - 8'd1);
    assign last_half = (half_q == LastHalf);

    // Half-period h holds sclk = CPOL ^ ~h[0]: entering an even h is a leading
    // edge, entering an odd h a trailing edge.
    assign enter_h0   = (state_q == StSetup) && phase_end;
    assign enter_next = (state_q == StXfer) && phase_end && !last_half;
    assign enter_even = enter_h0 || (enter_next && half_q[0]);
    assign enter_odd  = enter_next && !half_q[0];
    assign hold_entry = (state_q == StXfer) && phase_end && last_half;

    // CPHA=1 drives bit 0 during h0/h1, so its first leading edge must not shift.
    assign do_sample = act_cpha_q ? enter_odd : enter_even;
    assign do_shift  = act_cpha_q ? (enter_next && half_q[0]) : enter_odd;

    assign tx_bit = act_lsb_q ? tx_sh_q[0] : tx_sh_q[W_DATA-1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_start) state_d = StSetup;
            StSetup: if (phase_end) state_d = StXfer;
            StXfer:  if (phase_end && last_half) state_d = StHold;
            StHold:  if (phase_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = 1'b1;
        spi_cs_n = 1'b0;
        spi_sclk = act_cpol_q;
        spi_mosi = tx_bit;
        unique case (state_q)
            StIdle: begin
                busy     = 1'b0;
                spi_cs_n = 1'b1;
                // Idle level follows the programmed CPOL, not the last frame's.
                spi_sclk = cfg_cpol_q;
                spi_mosi = 1'b0;
            end
            StSetup, StHold: spi_sclk = act_cpol_q;
            StXfer:          spi_sclk = act_cpol_q ^ ~half_q[0];
            default: begin
                busy     = 1'b0;
                spi_cs_n = 1'b1;
                spi_sclk = cfg_cpol_q;
                spi_mosi = 1'b0;
            end
        endcase
    end

    assign irq = rx_dv_q && cfg_ie_q;

    // ------------------------------------------------------------------
    // Flag and holding-buffer next state
    // ------------------------------------------------------------------
    always_comb begin
        tx_pend_d = tx_pend_q;
        hold_d    = hold_q;
        if (start_pend) begin
            tx_pend_d = 1'b0;
        end
        // Any TX write that does not start a frame lands in the holding buffer.
        if (wr_tx && !start_new) begin
            hold_d    = wd;
            tx_pend_d = 1'b1;
        end
        // Set wins over a same-edge W1C / read clear.
        tx_ovr_d = (wr_tx && busy && tx_pend_q) || (tx_ovr_q && !(wr_stat && wd[3]));
        rx_ovr_d = (hold_entry && rx_dv_q) || (rx_ovr_q && !(wr_stat && wd[4]));
        rx_dv_d  = hold_entry || (rx_dv_q && !rd_rx);
    end

    // ------------------------------------------------------------------
    // Engine datapath and registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_cpha_q <= DefMode[0];
            act_cpol_q <= DefMode[1];
            act_lsb_q  <= 1'b0;
            act_div_q  <= DefDiv;
            cnt_q      <= 8'd0;
            half_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_q       <= '0;
            hold_q     <= '0;
            tx_pend_q  <= 1'b0;
            tx_ovr_q   <= 1'b0;
            rx_dv_q    <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            tx_pend_q <= tx_pend_d;
            tx_ovr_q  <= tx_ovr_d;
            rx_dv_q   <= rx_dv_d;
            rx_ovr_q  <= rx_ovr_d;

            if (frame_start) begin
                tx_sh_q    <= start_new ? wd : hold_q;
                rx_sh_q    <= '0;
                act_cpha_q <= cfg_cpha_q;
                act_cpol_q <= cfg_cpol_q;
                act_lsb_q  <= cfg_lsb_q;
                act_div_q  <= cfg_div_q;
            end else begin
                if (do_shift) begin
                    tx_sh_q <= act_lsb_q ? {1'b0, tx_sh_q[W_DATA-1:1]}
                                         : {tx_sh_q[W_DATA-2:0], 1'b0};
                end
                if (do_sample) begin
                    rx_sh_q <= act_lsb_q ? {spi_miso, rx_sh_q[W_DATA-1:1]}
                                         : {rx_sh_q[W_DATA-2:0], spi_miso};
                end
            end

            if (state_q == StIdle || phase_end) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (enter_h0) begin
                half_q <= '0;
            end else if (enter_next) begin
                half_q <= half_q + HalfW'(1);
            end

            if (hold_entry) begin
                rx_q <= rx_sh_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-visible CFG and scratch registers
    // ------------------------------------------------------------------
    assign wd16 = 16'(wd);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_cpha_q <= DefMode[0];
            cfg_cpol_q <= DefMode[1];
            cfg_lsb_q  <= 1'b0;
            cfg_ie_q   <= 1'b0;
            cfg_div_q  <= DefDiv;
        end else if (wr_cfg) begin
            cfg_cpha_q <= wd16[0];
            cfg_cpol_q <= wd16[1];
            cfg_lsb_q  <= wd16[2];
            cfg_ie_q   <= wd16[3];
            if (HasDiv) begin
                cfg_div_q <= wd16[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = AddrFirst; i < NumRegs; i++) begin
                scratch_q[i] <= '0;
            end
        end else if (write_en && addr >= AddrFirst) begin
            scratch_q[addr] <= wd;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    assign stat  = {rx_ovr_q, tx_ovr_q, tx_pend_q, rx_dv_q, busy};
    assign cfg16 = {cfg_div_q, 4'b0000, cfg_ie_q, cfg_lsb_q, cfg_cpol_q, cfg_cpha_q};

    always_comb begin
        rd_data = '0;
        if (addr == AddrRx) begin
            rd_data = rx_q;
        end else if (addr == AddrStat) begin
            rd_data = W_DATA'(stat);
        end else if (addr == AddrCfg) begin
            rd_data = W_DATA'(cfg16);
        end else if (addr >= AddrFirst) begin
            rd_data = scratch_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= read_en ? rd_data : '0;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_spi_master_regfile.sv
// Directed bench for spi_master_regfile: an 8-bit instance (div 2, mode 0)
// exercises the SPI engine, and a 32-bit instance exercises scratch/CFG width.
module tb_spi_master_regfile;

    localparam logic [1:0] MT = 2'b01;
    localparam logic [1:0] MF = 2'b10;

    logic       clk;
    logic       rst;
    logic [4:0] addr;
    logic [7:0] wd;
    logic [1:0] ctrl;
    logic [7:0] data_out;
    logic       spi_sclk, spi_mosi, spi_miso, spi_cs_n, irq;
    logic       loop_en, miso_val;

    logic [4:0]  b_addr;
    logic [31:0] b_wd;
    logic [1:0]  b_ctrl;
    logic [31:0] b_data_out;
    logic        b_sclk, b_mosi, b_cs_n, b_irq;
    logic        b_miso;

    int total = 0;
    int bad   = 0;

    // Frame monitor state (sampled on negedge).
    logic [7:0] cap;
    logic [7:0] frames [0:63];
    int         nf = 0;
    int         hi_cnt = 0;
    int         last_gap = 0;
    int         lo_cnt = 0;
    int         last_lo = 0;
    logic       sclk_prev, cs_prev;
    logic [31:0] rdv;

    assign spi_miso = loop_en ? spi_mosi : miso_val;
    assign b_miso   = 1'b0;

    spi_master_regfile #(
        .W_DATA  (8),
        .W_ADDR  (5),
        .W_CTRL  (2),
        .DEF_DIV (2),
        .DEF_MODE(0)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wd      (wd),
        .ctrl    (ctrl),
        .data_out(data_out),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n),
        .irq     (irq)
    );

    spi_master_regfile #(
        .W_DATA  (32),
        .W_ADDR  (5),
        .W_CTRL  (2),
        .DEF_DIV (4),
        .DEF_MODE(0)
    ) u_dut32 (
        .clk     (clk),
        .rst     (rst),
        .addr    (b_addr),
        .wd      (b_wd),
        .ctrl    (b_ctrl),
        .data_out(b_data_out),
        .spi_sclk(b_sclk),
        .spi_mosi(b_mosi),
        .spi_miso(b_miso),
        .spi_cs_n(b_cs_n),
        .irq     (b_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Captures mosi at each rising sclk (leading edge in mode 0), logs a frame
    // when cs_n rises, and measures cs_n low/high run lengths.
    always @(negedge clk) begin
        sclk_prev <= spi_sclk;
        cs_prev   <= spi_cs_n;
        if (!spi_cs_n && spi_sclk && !sclk_prev) cap <= {cap[6:0], spi_mosi};
        if (spi_cs_n && !cs_prev) begin
            frames[nf] <= cap;
            nf         <= nf + 1;
            last_lo    <= lo_cnt;
        end
        if (spi_cs_n) begin
            hi_cnt <= hi_cnt + 1;
        end else if (cs_prev) begin
            last_gap <= hi_cnt;
            hi_cnt   <= 0;
            lo_cnt   <= 1;
        end else begin
            lo_cnt <= lo_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mt(input logic [4:0] a, input logic [7:0] d);
        ctrl = MT;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1 ctrl = 2'b00;
    endtask

    task automatic mf(input logic [4:0] a, output logic [31:0] d);
        ctrl = MF;
        addr = a;
        @(posedge clk);
        #1 ctrl = 2'b00;
        d = {24'h0, data_out};
    endtask

    task automatic b_mt(input logic [4:0] a, input logic [31:0] d);
        b_ctrl = MT;
        b_addr = a;
        b_wd   = d;
        @(posedge clk);
        #1 b_ctrl = 2'b00;
    endtask

    task automatic b_mf(input logic [4:0] a, output logic [31:0] d);
        b_ctrl = MF;
        b_addr = a;
        @(posedge clk);
        #1 b_ctrl = 2'b00;
        d = b_data_out;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (nf < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("frame_timeout", {31'h0, nf >= target}, 32'h1);
    endtask

    initial begin
        int nf0;
        rst      = 1'b0;
        ctrl     = 2'b00;
        addr     = '0;
        wd       = '0;
        b_ctrl   = 2'b00;
        b_addr   = '0;
        b_wd     = '0;
        loop_en  = 1'b1;
        miso_val = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_cs_n", {31'h0, spi_cs_n}, 32'h1);
        chk("rst_sclk", {31'h0, spi_sclk}, 32'h0);
        chk("rst_mosi", {31'h0, spi_mosi}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        mf(5'd2, rdv);
        chk("rst_stat", rdv, 32'h0);
        mf(5'd3, rdv);
        chk("rst_cfg8", rdv, 32'h0);
        b_mf(5'd3, rdv);
        chk("rst_cfg32", rdv, 32'h0000_0400);

        // Mode 0 loopback of 8'hA5
        nf0 = nf;
        mt(5'd0, 8'hA5);
        wait_frames(nf0 + 1);
        chk("a5_mosi", {24'h0, cap}, 32'hA5);
        // div*(2*W+2) cycles with cs_n low, plus the write cycle = frame length
        chk("a5_cs_low", last_lo, 32'd36);
        mf(5'd2, rdv);
        chk("a5_stat", rdv, 32'h02);
        chk("a5_irq", {31'h0, irq}, 32'h0);
        mf(5'd1, rdv);
        chk("a5_rx", rdv, 32'hA5);
        mf(5'd0, rdv);
        chk("tx_reads_0", rdv, 32'h0);
        @(posedge clk);
        #1;
        chk("idle_data_out", {24'h0, data_out}, 32'h0);

        // Mode 3, ie=1, miso tied high (8-bit CFG write has no div field)
        mt(5'd3, 8'h0B);
        chk("m3_sclk_idle", {31'h0, spi_sclk}, 32'h1);
        loop_en  = 1'b0;
        miso_val = 1'b1;
        nf0 = nf;
        mt(5'd0, 8'h3C);
        wait_frames(nf0 + 1);
        chk("m3_sclk_after", {31'h0, spi_sclk}, 32'h1);
        chk("m3_irq_set", {31'h0, irq}, 32'h1);
        mf(5'd1, rdv);
        chk("m3_rx", rdv, 32'hFF);
        chk("m3_irq_clr", {31'h0, irq}, 32'h0);

        // Back-to-back writes: 11 sent, 22 overwritten by 33
        loop_en = 1'b1;
        mt(5'd3, 8'h00);
        nf0 = nf;
        mt(5'd0, 8'h11);
        mt(5'd0, 8'h22);
        mt(5'd0, 8'h33);
        mf(5'd2, rdv);
        chk("b2b_stat_busy", rdv, 32'h0D);
        wait_frames(nf0 + 2);
        chk("b2b_frame0", {24'h0, frames[nf0]}, 32'h11);
        chk("b2b_frame1", {24'h0, frames[nf0+1]}, 32'h33);
        chk("b2b_gap", {31'h0, last_gap >= 1}, 32'h1);
        mf(5'd2, rdv);
        chk("b2b_stat_ovr", rdv, 32'h1A);
        mt(5'd2, 8'h18);
        mf(5'd2, rdv);
        chk("w1c_stat", rdv, 32'h02);
        mf(5'd1, rdv);
        chk("b2b_rx", rdv, 32'h33);

        // Reset during XFER
        mt(5'd0, 8'h5A);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_cs_low", {31'h0, spi_cs_n}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk("abort_cs_n", {31'h0, spi_cs_n}, 32'h1);
        chk("abort_sclk", {31'h0, spi_sclk}, 32'h0);
        chk("abort_irq", {31'h0, irq}, 32'h0);
        mf(5'd2, rdv);
        chk("abort_stat", rdv, 32'h0);
        nf0 = nf;
        mt(5'd0, 8'h96);
        wait_frames(nf0 + 1);
        chk("post_rst_mosi", {24'h0, cap}, 32'h96);
        chk("post_rst_cs_low", last_lo, 32'd36);
        mf(5'd1, rdv);
        chk("post_rst_rx", rdv, 32'h96);

        // LSB first
        mt(5'd3, 8'h04);
        nf0 = nf;
        mt(5'd0, 8'h01);
        wait_frames(nf0 + 1);
        chk("lsb_mosi", {24'h0, cap}, 32'h80);
        mf(5'd1, rdv);
        chk("lsb_rx", rdv, 32'h01);

        // 32-bit scratch
        b_mt(5'd7, 32'hDEADBEEF);
        b_mf(5'd7, rdv);
        chk("scratch7", rdv, 32'hDEADBEEF);
        b_mf(5'd5, rdv);
        chk("scratch5_rst", rdv, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
